// File: rtl/child_rx_if.sv
// Bundle of the child_rx serial input and valid/ready word output.
// The slave modport is the receiver's view; master is the environment's view.
interface child_rx_if #(
    parameter int WIDTH = 8
);
    logic             child_o;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             frame_err;
    logic             overrun;

    modport master (
        output child_o, ready,
        input  data, valid, frame_err, overrun
    );

    modport slave (
        input  child_o, ready,
        output data, valid, frame_err, overrun
    );
endinterface

// File: rtl/child_rx.sv
// Serial frame receiver for the CHILD.O line: mid-bit sampling, stop-bit check,
// one-entry valid/ready output buffer with framing-error and overrun pulses.
module child_rx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input logic       clk,
    input logic       rst_n,
    child_rx_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             sync_q, s_q;
    logic             good_frame, consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 1'b1;
            s_q         <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= bus.child_o;
            s_q         <= sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        good_frame  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!s_q) begin
                    state_d = START;
                    cnt_d   = HALF;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    // A start bit that is high again at mid-bit is treated as a glitch.
                    if (!s_q) begin
                        state_d = DATA;
                        cnt_d   = FULL;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = s_q;
                    cnt_d          = FULL;
                    if (idx_q == LAST) state_d = STOP;
                    else               idx_d   = idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (s_q) begin
                        good_frame = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A word completing in the same cycle the buffer is drained still fits.
    always_comb begin
        consume   = valid_q && bus.ready;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (consume) valid_d = 1'b0;
        if (good_frame) begin
            if (!valid_q || consume) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_child_rx.sv
// Directed bench for child_rx (WIDTH=8, DIV=4): frames, glitch, bad stop,
// overrun, simultaneous consume/load and reset mid-frame.
module tb_child_rx;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   fe_cnt, ov_cnt, vd_cnt;
    int   fe0, ov0, vd0;
    logic [7:0] last_data;

    child_rx_if #(.WIDTH(8)) bus ();

    child_rx #(.WIDTH(8), .DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/cycle counters so pulse widths and counts can be compared as deltas.
    initial begin
        fe_cnt = 0;
        ov_cnt = 0;
        vd_cnt = 0;
        last_data = 8'h00;
    end
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (bus.overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
        if (bus.valid === 1'b1) begin
            vd_cnt    <= vd_cnt + 1;
            last_data <= bus.data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic b);
        bus.child_o = b;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(stop);
    endtask

    task automatic idle(input int n);
        bus.child_o = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        @(negedge clk);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        vd0 = vd_cnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.child_o = 1'b1;
        bus.ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_data", 32'(bus.data), 32'h00);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check("reset_overrun", 32'(bus.overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // Single frame, ready high
        bus.ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        idle(6);
        @(negedge clk);
        check("single_valid_cycles", 32'(vd_cnt - vd0), 32'd1);
        check("single_data", 32'(last_data), 32'hA5);
        check("single_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("single_overrun", 32'(ov_cnt - ov0), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back frames with ready tied high
        snap();
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(6);
        @(negedge clk);
        check("b2b_valid_cycles", 32'(vd_cnt - vd0), 32'd2);
        check("b2b_data", 32'(last_data), 32'hC3);
        check("b2b_overrun", 32'(ov_cnt - ov0), 32'd0);
        @(posedge clk);
        #1;

        // Glitch: one-cycle low pulse
        snap();
        bus.child_o = 1'b0;
        @(posedge clk);
        #1;
        idle(12);
        @(negedge clk);
        check("glitch_valid", 32'(vd_cnt - vd0), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("glitch_overrun", 32'(ov_cnt - ov0), 32'd0);
        @(posedge clk);
        #1;

        // Bad stop bit, line stays low, then a good frame
        snap();
        send_frame(8'h3C, 1'b0);
        bus.child_o = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(8);
        @(negedge clk);
        check("badstop_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("badstop_valid", 32'(vd_cnt - vd0), 32'd0);
        check("badstop_overrun", 32'(ov_cnt - ov0), 32'd0);
        @(posedge clk);
        #1;
        send_frame(8'h81, 1'b1);
        idle(6);
        @(negedge clk);
        check("after_bad_valid_cycles", 32'(vd_cnt - vd0), 32'd1);
        check("after_bad_data", 32'(last_data), 32'h81);
        check("after_bad_frame_err", 32'(fe_cnt - fe0), 32'd1);
        @(posedge clk);
        #1;

        // Overrun with ready low
        bus.ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b1);
        idle(6);
        @(negedge clk);
        check("overrun_valid", 32'(bus.valid), 32'd1);
        check("overrun_data", 32'(bus.data), 32'h11);
        check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("overrun_frame_err", 32'(fe_cnt - fe0), 32'd0);
        @(posedge clk);
        #1;
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        @(negedge clk);
        check("consume_valid", 32'(bus.valid), 32'd0);
        check("consume_data_hold", 32'(bus.data), 32'h11);
        @(posedge clk);
        #1;

        // Simultaneous consume and load
        send_frame(8'h33, 1'b1);
        idle(4);
        @(negedge clk);
        check("preload_valid", 32'(bus.valid), 32'd1);
        check("preload_data", 32'(bus.data), 32'h33);
        @(posedge clk);
        #1;
        snap();
        send_frame(8'h44, 1'b1);
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        @(negedge clk);
        check("simul_valid", 32'(bus.valid), 32'd1);
        check("simul_data", 32'(bus.data), 32'h44);
        check("simul_overrun", 32'(ov_cnt - ov0), 32'd0);
        @(posedge clk);
        #1;
        idle(4);

        // Reset during data bit 4 of frame 0xFF
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        bus.child_o = 1'b1;
        @(posedge clk);
        #1;
        check("prereset_valid", 32'(bus.valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check("midreset_valid", 32'(bus.valid), 32'd0);
        check("midreset_data", 32'(bus.data), 32'h00);
        check("midreset_frame_err", 32'(bus.frame_err), 32'd0);
        check("midreset_overrun", 32'(bus.overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ready = 1'b1;
        idle(8);
        snap();
        send_frame(8'h5A, 1'b1);
        idle(6);
        @(negedge clk);
        check("postreset_valid_cycles", 32'(vd_cnt - vd0), 32'd1);
        check("postreset_data", 32'(last_data), 32'h5A);
        check("postreset_frame_err", 32'(fe_cnt - fe0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
